// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: command and status bundle for the LED sequencer.
//
// Handshake semantics: there is no valid/ready pair on this bundle. Each
// command (start_i, stop_i, dir_i, mode_i) is a single-cycle pulse that is
// sampled on exactly one rising clk edge and always accepted or discarded in
// that same cycle by the command priority rules. The controller cannot stall
// a command. step_o is a one-cycle pulse marking the cycle in which the
// pattern advances. The remaining outputs are level signals.
// state_dbg exposes the controller state (0 IDLE, 1 RUN, 2 PAUSE) for checkers.
interface led_seq_ctrl_if #(
  parameter int unsigned LED_W = 6
);
  logic             start_i;
  logic             stop_i;
  logic             dir_i;
  logic             mode_i;
  logic [LED_W-1:0] led_o;
  logic             step_o;
  logic             busy_o;
  logic             mode_o;
  logic             dir_o;
  logic [1:0]       state_dbg;

  // Command source (button front-end or testbench)
  modport master (
    output start_i, stop_i, dir_i, mode_i,
    input  led_o, step_o, busy_o, mode_o, dir_o, state_dbg
  );

  // The sequencer itself
  modport slave (
    input  start_i, stop_i, dir_i, mode_i,
    output led_o, step_o, busy_o, mode_o, dir_o, state_dbg
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: run/pause sequencer for the LED display.
// A prescaler divides clk by TICK_COUNT. On every tick while running, the
// pattern advances: either a binary count (up/down, modulo 2^LED_W) or a
// one-hot scan that bounces between the two end LEDs.
// Optional build macro LED_ACTIVE_LOW_EN: drive led_o inverted (LED on = 0).
module led_seq_ctrl #(
  parameter int unsigned TICK_COUNT = 13500000,
  parameter int unsigned LED_W      = 6
) (
  input logic         clk,
  input logic         rst,
  led_seq_ctrl_if.slave bus
);

  localparam int unsigned      PW         = $clog2(TICK_COUNT);
  localparam logic [PW-1:0]    TERM       = PW'(TICK_COUNT - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [LED_W-1:0] VAL_ONE    = LED_W'(1);
  localparam logic [LED_W-1:0] POS_TOP    = LED_W'(LED_W - 1);
  localparam logic [LED_W-1:0] POS_BELOW  = LED_W'(LED_W - 2);
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [LED_W-1:0] LED_RST    = '1;
`else
  localparam logic [LED_W-1:0] LED_RST    = '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [PW-1:0]    presc_q, presc_n;
  // Binary value in BINARY mode, one-hot position in SCAN mode.
  logic [LED_W-1:0] val_q, val_n;
  logic             mode_q, mode_n;
  logic             dir_q, dir_n;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] pat_n;
  logic             mode_acc, dir_acc, tick, adv;

  // Next-state, prescaler and pattern logic; later assignments override earlier ones.
  always_comb begin
    state_n  = state_q;
    presc_n  = presc_q;
    val_n    = val_q;
    mode_n   = mode_q;
    dir_n    = dir_q;
    pat_n    = '0;

    // mode/dir only count when no start/stop is present this cycle
    mode_acc = bus.mode_i & ~bus.stop_i & ~bus.start_i;
    dir_acc  = bus.dir_i  & ~bus.stop_i & ~bus.start_i;
    tick     = (state_q == ST_RUN) && (presc_q == TERM);
    // A mode change on the tick cycle clears instead of stepping
    adv      = tick & ~mode_acc;

    if (state_q == ST_RUN) begin
      presc_n = tick ? '0 : presc_q + PRESC_ONE;
    end

    // Pattern step always uses the direction held before this cycle
    if (adv) begin
      if (!mode_q) begin
        val_n = dir_q ? val_q - VAL_ONE : val_q + VAL_ONE;
      end else if (!dir_q) begin
        if (val_q == POS_TOP) begin
          val_n = POS_BELOW;
          dir_n = 1'b1;
        end else begin
          val_n = val_q + VAL_ONE;
        end
      end else begin
        if (val_q == '0) begin
          val_n = VAL_ONE;
          dir_n = 1'b0;
        end else begin
          val_n = val_q - VAL_ONE;
        end
      end
    end

    if (bus.stop_i) begin
      if (state_q == ST_RUN) begin
        state_n = ST_PAUSE;
        // Freeze the prescaler where it stands; a step on this cycle still wraps it
        if (!tick) presc_n = presc_q;
      end else begin
        state_n = ST_IDLE;
      end
    end else if (bus.start_i) begin
      if (state_q == ST_IDLE) begin
        state_n = ST_RUN;
        presc_n = '0;
      end else if (state_q == ST_PAUSE) begin
        state_n = ST_RUN;
      end
    end

    if (mode_acc) begin
      mode_n  = ~mode_q;
      val_n   = '0;
      presc_n = '0;
    end

    // Toggle after any automatic bounce flip so the two cancel at an end LED
    if (dir_acc) dir_n = ~dir_n;

    if (state_n == ST_IDLE) begin
      presc_n = '0;
      val_n   = '0;
    end

    pat_n = mode_n ? (VAL_ONE << val_n) : val_n;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      val_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      led_q   <= LED_RST;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      val_q   <= val_n;
      mode_q  <= mode_n;
      dir_q   <= dir_n;
`ifdef LED_ACTIVE_LOW_EN
      led_q   <= ~pat_n;
`else
      led_q   <= pat_n;
`endif
    end
  end

  assign bus.led_o     = led_q;
  assign bus.step_o    = adv & ~rst;
  assign bus.busy_o    = (state_q == ST_RUN);
  assign bus.mode_o    = mode_q;
  assign bus.dir_o     = dir_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed scenarios plus randomized pulses against a
// behavioural model of the LED sequencer (TICK_COUNT=4, LED_W=6, active-high LEDs).
module tb_led_seq_ctrl;

  localparam int TC = 4;
  localparam int LW = 6;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_seq_ctrl_if #(.LED_W(LW)) bus();

  led_seq_ctrl #(.TICK_COUNT(TC), .LED_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [LW-1:0] exp_q[$];

  int m_state, m_phase, m_val, m_pos;
  bit m_mode, m_dir;
  bit exp_step, obs_step;

  function automatic logic [LW-1:0] model_led();
    if (m_mode) return LW'(1 << m_pos);
    return LW'(m_val);
  endfunction

  function automatic bit model_step(input bit st, input bit sp, input bit md);
    return (m_state == M_RUN) && (m_phase == TC - 1) && !(md && !sp && !st);
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_phase = 0; m_val = 0; m_pos = 0;
    m_mode = 1'b0; m_dir = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_update(input bit st, input bit sp, input bit dr, input bit md, input bit stp);
    bit mode_acc, dir_acc;
    int np;
    mode_acc = md && !sp && !st;
    dir_acc  = dr && !sp && !st;
    if (stp) begin
      if (!m_mode) begin
        m_val = (m_val + (m_dir ? (1 << LW) - 1 : 1)) % (1 << LW);
      end else begin
        np = m_pos + (m_dir ? -1 : 1);
        if (np > LW - 1) begin np = LW - 2; m_dir = 1'b1; end
        else if (np < 0) begin np = 1; m_dir = 1'b0; end
        m_pos = np;
      end
    end
    // Period counting runs in RUN; a pause freezes it except on a completing step
    if (m_state == M_RUN && (!sp || m_phase == TC - 1)) m_phase = (m_phase + 1) % TC;
    if (sp) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
      else m_state = M_IDLE;
    end else if (st) begin
      if (m_state == M_IDLE) begin m_state = M_RUN; m_phase = 0; end
      else if (m_state == M_PAUSE) m_state = M_RUN;
    end else begin
      if (mode_acc) begin m_mode = !m_mode; m_val = 0; m_pos = 0; m_phase = 0; end
      if (dir_acc) m_dir = !m_dir;
    end
    if (m_state == M_IDLE) begin m_phase = 0; m_val = 0; m_pos = 0; end
    if (stp) exp_q.push_back(model_led());
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_cmds();
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.dir_i = 1'b0; bus.mode_i = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic drive_cycle(input bit st, input bit sp, input bit dr, input bit md);
    bus.start_i = st; bus.stop_i = sp; bus.dir_i = dr; bus.mode_i = md;
    exp_step = model_step(st, sp, md);
    @(negedge clk);
    obs_step = bus.step_o;
    model_update(st, sp, dr, md, exp_step);
    @(posedge clk);
    #1;
    clear_cmds();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.start_i = 1'($urandom_range(0, 1));
    bus.stop_i  = 1'($urandom_range(0, 1));
    bus.dir_i   = 1'($urandom_range(0, 1));
    bus.mode_i  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_cmds();
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b1; bus.stop_i = 1'b0; bus.dir_i = 1'b1; bus.mode_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.step_o !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %b want 0", bus.step_o); end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.led_o, bus.busy_o, bus.mode_o, bus.dir_o} !== 9'h000)
      begin n_bad++; $display("FAIL reset_outputs: led=%h busy=%b mode=%b dir=%b want all 0", bus.led_o, bus.busy_o, bus.mode_o, bus.dir_o); end
    rst = 1'b0;
    clear_cmds();
    model_reset();
    drive_cycle(0, 0, 0, 0);
    n_cmp++;
    if ({bus.led_o, bus.busy_o, obs_step} !== 8'h00)
      begin n_bad++; $display("FAIL idle_hold: led=%h busy=%b step=%b want 0", bus.led_o, bus.busy_o, obs_step); end
  endtask

  task automatic test_count_up();
    int sc[$];
    int k;
    apply_reset();
    drive_cycle(1, 0, 0, 0);
    n_cmp++;
    if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL count_busy: got %b want 1", bus.busy_o); end
    k = 0;
    for (int c = 1; c <= 12; c++) begin
      drive_cycle(0, 0, 0, 0);
      if (obs_step) begin
        sc.push_back(c);
        k++;
        n_cmp++;
        if (bus.led_o !== LW'(k)) begin n_bad++; $display("FAIL count_led: step %0d got %h want %h", k, bus.led_o, LW'(k)); end
      end
    end
    n_cmp++;
    if (sc.size() != 3 || sc[0] != 4 || sc[1] != 8 || sc[2] != 12)
      begin n_bad++; $display("FAIL count_step_cycles: got %0d steps (%p) want cycles 4,8,12", sc.size(), sc); end
  endtask

  task automatic test_down_wrap();
    logic [LW-1:0] got[$];
    apply_reset();
    drive_cycle(0, 0, 1, 0);
    n_cmp++;
    if ({bus.dir_o, bus.busy_o} !== 2'b10) begin n_bad++; $display("FAIL down_dir_idle: dir=%b busy=%b want 1 0", bus.dir_o, bus.busy_o); end
    drive_cycle(1, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(0, 0, 0, 0);
      if (obs_step) got.push_back(bus.led_o);
    end
    n_cmp++;
    if (got.size() != 2 || got[0] !== 6'h3F || got[1] !== 6'h3E)
      begin n_bad++; $display("FAIL down_wrap: got %p want 3f,3e", got); end
  endtask

  task automatic test_pause_resume();
    int nsteps, off;
    apply_reset();
    drive_cycle(1, 0, 0, 0);
    for (int c = 1; c <= 5; c++) drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);
    nsteps = 0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(0, 0, 0, 0);
      if (obs_step) nsteps++;
    end
    n_cmp++;
    if (nsteps != 0 || bus.busy_o !== 1'b0 || bus.led_o !== 6'h01)
      begin n_bad++; $display("FAIL pause_frozen: steps=%0d busy=%b led=%h want 0 0 01", nsteps, bus.busy_o, bus.led_o); end
    drive_cycle(1, 0, 0, 0);
    off = 0;
    for (int i = 1; i <= 6 && off == 0; i++) begin
      drive_cycle(0, 0, 0, 0);
      if (obs_step) off = i;
    end
    n_cmp++;
    if (off != 3) begin n_bad++; $display("FAIL resume_latency: got %0d want 3", off); end
    n_cmp++;
    if (bus.led_o !== 6'h02) begin n_bad++; $display("FAIL resume_value: got %h want 02", bus.led_o); end
  endtask

  task automatic test_scan_bounce();
    logic [LW-1:0] got[$];
    logic [LW-1:0] scan_exp[7];
    scan_exp = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10, 6'h08};
    apply_reset();
    drive_cycle(0, 0, 0, 1);
    n_cmp++;
    if ({bus.mode_o, bus.led_o} !== 7'b1_000001) begin n_bad++; $display("FAIL scan_enter: mode=%b led=%h want 1 01", bus.mode_o, bus.led_o); end
    drive_cycle(1, 0, 0, 0);
    for (int c = 0; c < 28; c++) begin
      drive_cycle(0, 0, 0, 0);
      if (obs_step) got.push_back(bus.led_o);
    end
    n_cmp++;
    if (got.size() != 7) begin n_bad++; $display("FAIL scan_count: got %0d steps want 7", got.size()); end
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== scan_exp[i]) begin n_bad++; $display("FAIL scan_step%0d: got %h want %h", i + 1, got[i], scan_exp[i]); end
    end
    n_cmp++;
    if (bus.dir_o !== 1'b1) begin n_bad++; $display("FAIL scan_dir: got %b want 1", bus.dir_o); end
  endtask

  task automatic test_stop_start_same();
    int nsteps;
    apply_reset();
    drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0);
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL stop_start_busy: got %b want 0", bus.busy_o); end
    nsteps = 0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(0, 0, 0, 0);
      if (obs_step) nsteps++;
    end
    n_cmp++;
    if (nsteps != 0 || bus.led_o !== 6'h00) begin n_bad++; $display("FAIL stop_start_frozen: steps=%0d led=%h want 0 00", nsteps, bus.led_o); end
  endtask

  task automatic test_stop_on_step();
    int nsteps;
    apply_reset();
    drive_cycle(1, 0, 0, 0);
    for (int c = 1; c <= 3; c++) drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 1, 0, 0);
    n_cmp++;
    if (obs_step !== 1'b1) begin n_bad++; $display("FAIL stop_step_pulse: got %b want 1", obs_step); end
    n_cmp++;
    if ({bus.led_o, bus.busy_o} !== 7'b000001_0) begin n_bad++; $display("FAIL stop_step_state: led=%h busy=%b want 01 0", bus.led_o, bus.busy_o); end
    nsteps = 0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(0, 0, 0, 0);
      if (obs_step) nsteps++;
    end
    n_cmp++;
    if (nsteps != 0 || bus.led_o !== 6'h01) begin n_bad++; $display("FAIL stop_step_frozen: steps=%0d led=%h want 0 01", nsteps, bus.led_o); end
  endtask

  task automatic test_rst_mid_run();
    apply_reset();
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 1, 0);
    drive_cycle(1, 0, 0, 0);
    for (int c = 0; c < 10; c++) drive_cycle(0, 0, 0, 0);
    rst = 1'b1;
    bus.start_i = 1'b1; bus.mode_i = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.led_o, bus.busy_o, bus.mode_o, bus.dir_o} !== 9'h000)
      begin n_bad++; $display("FAIL rst_mid_run: led=%h busy=%b mode=%b dir=%b want all 0", bus.led_o, bus.busy_o, bus.mode_o, bus.dir_o); end
    rst = 1'b0;
    clear_cmds();
    model_reset();
  endtask

  task automatic test_random();
    bit st, sp, dr, md;
    logic [LW-1:0] want_led, popped;
    int first_bad;
    apply_reset();
    first_bad = 0;
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 19) == 0);
      dr = ($urandom_range(0, 15) == 0);
      md = ($urandom_range(0, 23) == 0);
      drive_cycle(st, sp, dr, md);
      n_cmp++;
      if (obs_step !== exp_step) begin
        n_bad++;
        if (first_bad++ < 10) $display("FAIL rand_step: cycle %0d got %b want %b", c, obs_step, exp_step);
      end
      want_led = model_led();
      n_cmp++;
      if ({bus.led_o, bus.busy_o, bus.mode_o, bus.dir_o} !== {want_led, m_state == M_RUN, m_mode, m_dir}) begin
        n_bad++;
        if (first_bad++ < 10)
          $display("FAIL rand_state: cycle %0d led=%h busy=%b mode=%b dir=%b want %h %b %b %b",
                   c, bus.led_o, bus.busy_o, bus.mode_o, bus.dir_o, want_led, m_state == M_RUN, m_mode, m_dir);
      end
      if (obs_step) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          if (first_bad++ < 10) $display("FAIL rand_sb_empty: cycle %0d step seen, led=%h, none expected", c, bus.led_o);
        end else begin
          popped = exp_q.pop_front();
          if (bus.led_o !== popped) begin
            n_bad++;
            if (first_bad++ < 10) $display("FAIL rand_sb_led: cycle %0d got %h want %h", c, bus.led_o, popped);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_sb_leftover: %0d expected steps not seen want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_cmds();
    model_reset();
    test_reset();
    test_count_up();
    test_down_wrap();
    test_pause_resume();
    test_scan_bounce();
    test_stop_start_same();
    test_stop_on_step();
    test_rst_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
